// File: rtl/ifetch_axi_lite_master_pkg.sv
// Shared types and constants for the instruction-fetch AXI4-Lite read initiator.
// Default widths match the instruction-memory slave.
package ifetch_axi_lite_master_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    // Low address bits that must be zero for a word-aligned fetch
    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } fetch_state_e;

    function automatic logic isMisaligned(input logic [1:0] lowBits);
        return (lowBits & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/ifetch_axi_lite_master.sv
// Single-outstanding AXI4-Lite read initiator for instruction fetch.
// Flushed transactions still complete on AXI, but their data is never presented to the core.
module ifetch_axi_lite_master
    import ifetch_axi_lite_master_pkg::*;
#(
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter bit CHECK_ALIGN = 1'b1
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic                  i_flush,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [DATA_WIDTH-1:0] o_rsp_data,
    output logic [ADDR_WIDTH-1:0] o_rsp_addr,
    output logic                  o_rsp_err,
    output logic [ADDR_WIDTH-1:0] o_axi_araddr,
    output logic                  o_axi_arvalid,
    input  logic                  i_axi_arready,
    input  logic [DATA_WIDTH-1:0] i_axi_rdata,
    input  logic                  i_axi_rvalid,
    output logic                  o_axi_rready
);

    fetch_state_e          state_q;
    logic                  drop_q;
    logic                  err_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] data_q;

    // drop_q marks the outstanding read as flushed; its data is swallowed on the R handshake
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (i_req_valid) begin
                        addr_q <= i_req_addr;
                        if (CHECK_ALIGN && isMisaligned(i_req_addr[1:0])) begin
                            state_q <= RESP;
                            err_q   <= 1'b1;
                            data_q  <= '0;
                        end else begin
                            state_q <= ADDR;
                            err_q   <= 1'b0;
                        end
                    end
                end
                ADDR: begin
                    if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                    if (i_axi_arready) begin
                        state_q <= DATA;
                    end
                end
                DATA: begin
                    if (i_axi_rvalid) begin
                        data_q  <= i_axi_rdata;
                        drop_q  <= 1'b0;
                        state_q <= (drop_q || i_flush) ? IDLE : RESP;
                    end else if (i_flush) begin
                        drop_q <= 1'b1;
                    end
                end
                RESP: begin
                    if (i_rsp_ready || i_flush) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Handshake outputs decode straight from the state register
    assign o_req_ready   = resetn && (state_q == IDLE);
    assign o_axi_arvalid = (state_q == ADDR);
    assign o_axi_rready  = (state_q == DATA);
    assign o_rsp_valid   = (state_q == RESP);
    assign o_axi_araddr  = addr_q;
    assign o_rsp_addr    = addr_q;
    assign o_rsp_data    = data_q;
    assign o_rsp_err     = err_q;

endmodule

// File: tb/tb_ifetch_axi_lite_master.sv
// Self-checking bench for ifetch_axi_lite_master: directed scenarios plus randomized fetches
// against an AXI-Lite memory responder and a word-level reference model.
`timescale 1ns/1ps
module tb_ifetch_axi_lite_master;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          i_req_valid = 1'b0;
    logic          o_req_ready;
    logic [AW-1:0] i_req_addr = '0;
    logic          i_flush = 1'b0;
    logic          o_rsp_valid;
    logic          i_rsp_ready = 1'b0;
    logic [DW-1:0] o_rsp_data;
    logic [AW-1:0] o_rsp_addr;
    logic          o_rsp_err;
    logic [AW-1:0] o_axi_araddr;
    logic          o_axi_arvalid;
    logic          i_axi_arready;
    logic [DW-1:0] i_axi_rdata;
    logic          i_axi_rvalid;
    logic          o_axi_rready;

    int nAsserts = 0;
    int nFails = 0;

    int arDlyCfg = 0;
    int rDlyCfg = 0;
    int arCount = 0;
    int arValidCycles = 0;
    int stabilityErrs = 0;
    logic [AW-1:0] lastAraddr = '0;

    ifetch_axi_lite_master #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .CHECK_ALIGN(1'b1)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_addr   (i_req_addr),
        .i_flush      (i_flush),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_addr   (o_rsp_addr),
        .o_rsp_err    (o_rsp_err),
        .o_axi_araddr (o_axi_araddr),
        .o_axi_arvalid(o_axi_arvalid),
        .i_axi_arready(i_axi_arready),
        .i_axi_rdata  (i_axi_rdata),
        .i_axi_rvalid (i_axi_rvalid),
        .o_axi_rready (o_axi_rready)
    );

    always #5 clk = ~clk;

    // Contents of the instruction memory seen through the AXI slave
    function automatic logic [DW-1:0] memWord(input logic [AW-1:0] a);
        if (a == 32'h0000_0010) return 32'h0051_3093;
        return (a * 32'h9E37_79B1) ^ 32'hA5A5_0F0F;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        nAsserts++;
        assert (observed === expected) else begin
            nFails++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [AW-1:0] addr, input logic flush, input logic rspReady);
        i_req_valid = valid;
        i_req_addr  = addr;
        i_flush     = flush;
        i_rsp_ready = rspReady;
    endtask

    // Stimulus acts 1ns after each falling edge, well away from the rising edge
    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    // AXI-Lite read slave: arready after arDlyCfg waiting cycles, rvalid rDlyCfg cycles after AR
    initial begin : axiSlave
        bit prevArHs, prevRHs, arSeen, haveR;
        logic [AW-1:0] prevAraddr, pendAddr, stableAddr;
        int arWait, rWait;
        prevArHs = 0; prevRHs = 0; arSeen = 0; haveR = 0;
        prevAraddr = '0; pendAddr = '0; stableAddr = '0;
        arWait = 0; rWait = 0;
        i_axi_arready = 1'b0;
        i_axi_rvalid  = 1'b0;
        i_axi_rdata   = '0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                prevArHs = 0; prevRHs = 0; arSeen = 0; haveR = 0;
                i_axi_arready = 1'b0;
                i_axi_rvalid  = 1'b0;
            end else begin
                if (prevArHs) begin
                    i_axi_arready = 1'b0;
                    arSeen = 0;
                    haveR = 1;
                    pendAddr = prevAraddr;
                    lastAraddr = prevAraddr;
                    rWait = rDlyCfg;
                    arCount++;
                end
                if (prevRHs) begin
                    i_axi_rvalid = 1'b0;
                    haveR = 0;
                end
                if (o_axi_arvalid) arValidCycles++;
                if (o_axi_arvalid && !i_axi_arready) begin
                    if (!arSeen) begin
                        arSeen = 1;
                        arWait = arDlyCfg;
                        stableAddr = o_axi_araddr;
                    end else if (o_axi_araddr !== stableAddr) begin
                        stabilityErrs++;
                    end
                    if (arWait == 0) i_axi_arready = 1'b1;
                    else arWait--;
                end
                if (haveR && !i_axi_rvalid) begin
                    if (rWait == 0) begin
                        i_axi_rvalid = 1'b1;
                        i_axi_rdata  = memWord(pendAddr);
                    end else begin
                        rWait--;
                    end
                end
                prevArHs   = o_axi_arvalid && i_axi_arready;
                prevAraddr = o_axi_araddr;
                prevRHs    = i_axi_rvalid && o_axi_rready;
            end
        end
    end

    // One fetch. flushAt>0 raises flush for flushLen cycles starting flushAt cycles after acceptance.
    // endMode: 0 = consume with rsp_ready, 1 = flush the held response, 2 = flush and rsp_ready together.
    task automatic runFetch(input logic [AW-1:0] addr, input int a, input int r, input int hold,
                            input int flushAt, input int flushLen, input int endMode);
        bit mis;
        bit sawRsp;
        int lat;
        int arBefore;
        int avBefore;
        logic [DW-1:0] expData;
        mis = (addr[1:0] != 2'b00);
        expData = mis ? '0 : memWord(addr);
        arDlyCfg = a;
        rDlyCfg = r;
        arBefore = arCount;
        avBefore = arValidCycles;
        checkOutput("req_ready_idle", 64'(o_req_ready), 64'd1);
        applyStimulus(1'b1, addr, 1'b0, 1'b0);
        if (flushAt > 0 && !mis) begin
            sawRsp = 0;
            for (int k = 1; k <= a + r + 5; k++) begin
                tick;
                i_req_valid = 1'b0;
                i_flush = (k >= flushAt) && (k < flushAt + flushLen);
                if (o_rsp_valid) sawRsp = 1;
            end
            i_flush = 1'b0;
            tick;
            if (o_rsp_valid) sawRsp = 1;
            checkOutput("flush_no_rsp", 64'(sawRsp), 64'd0);
            checkOutput("flush_req_ready", 64'(o_req_ready), 64'd1);
            checkOutput("flush_ar_count", 64'(arCount - arBefore), 64'd1);
            checkOutput("flush_araddr", 64'(lastAraddr), 64'(addr));
            return;
        end
        tick;
        i_req_valid = 1'b0;
        lat = 1;
        while (!o_rsp_valid && lat < 40) begin
            tick;
            lat++;
        end
        checkOutput("rsp_latency", 64'(lat), mis ? 64'd1 : 64'(a + r + 3));
        checkOutput("rsp_data", 64'(o_rsp_data), 64'(expData));
        checkOutput("rsp_addr", 64'(o_rsp_addr), 64'(addr));
        checkOutput("rsp_err", 64'(o_rsp_err), 64'(mis));
        checkOutput("req_ready_busy", 64'(o_req_ready), 64'd0);
        if (mis) begin
            checkOutput("mis_no_arvalid", 64'(arValidCycles - avBefore), 64'd0);
        end else begin
            checkOutput("ar_count", 64'(arCount - arBefore), 64'd1);
            checkOutput("araddr", 64'(lastAraddr), 64'(addr));
        end
        for (int h = 0; h < hold; h++) begin
            tick;
            checkOutput("hold_valid", 64'(o_rsp_valid), 64'd1);
            checkOutput("hold_data", 64'(o_rsp_data), 64'(expData));
            checkOutput("hold_addr", 64'(o_rsp_addr), 64'(addr));
            checkOutput("hold_req_ready", 64'(o_req_ready), 64'd0);
        end
        applyStimulus(1'b0, '0, endMode != 0, endMode != 1);
        tick;
        applyStimulus(1'b0, '0, 1'b0, 1'b0);
        checkOutput("rsp_done_valid", 64'(o_rsp_valid), 64'd0);
        checkOutput("rsp_done_req_ready", 64'(o_req_ready), 64'd1);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic [AW-1:0] addr;
        int a, r, hold, fAt, fLen, endMode;

        #1;
        checkOutput("reset_req_ready", 64'(o_req_ready), 64'd0);
        checkOutput("reset_arvalid", 64'(o_axi_arvalid), 64'd0);
        checkOutput("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
        checkOutput("reset_rready", 64'(o_axi_rready), 64'd0);
        checkOutput("reset_araddr", 64'(o_axi_araddr), 64'd0);
        tick;
        tick;
        resetn = 1'b1;
        #1;
        checkOutput("post_reset_req_ready", 64'(o_req_ready), 64'd1);

        // Directed scenarios
        runFetch(32'h0000_0010, 1, 1, 0, 0, 0, 0);
        runFetch(32'h0000_0040, 3, 2, 0, 0, 0, 0);
        checkOutput("araddr_stable", 64'(stabilityErrs), 64'd0);
        runFetch(32'h0000_0006, 0, 0, 0, 0, 0, 0);
        runFetch(32'h0000_0024, 2, 1, 0, 1, 1, 0);
        runFetch(32'h0000_0020, 1, 1, 0, 0, 0, 0);
        runFetch(32'h0000_0030, 1, 1, 5, 0, 0, 1);
        runFetch(32'h0000_0044, 0, 0, 2, 0, 0, 2);
        runFetch(32'h0000_0048, 0, 2, 0, 3, 3, 0);

        // Reset pulsed while the read is waiting for data
        arDlyCfg = 0;
        rDlyCfg = 3;
        applyStimulus(1'b1, 32'h0000_0008, 1'b0, 1'b0);
        tick;
        i_req_valid = 1'b0;
        tick;
        checkOutput("rready_in_data", 64'(o_axi_rready), 64'd1);
        #1 resetn = 1'b0;
        #1;
        checkOutput("async_reset_req_ready", 64'(o_req_ready), 64'd0);
        checkOutput("async_reset_rready", 64'(o_axi_rready), 64'd0);
        checkOutput("async_reset_arvalid", 64'(o_axi_arvalid), 64'd0);
        checkOutput("async_reset_rsp_data", 64'(o_rsp_data), 64'd0);
        checkOutput("async_reset_rsp_addr", 64'(o_rsp_addr), 64'd0);
        tick;
        resetn = 1'b1;
        #1;
        checkOutput("release_req_ready", 64'(o_req_ready), 64'd1);
        runFetch(32'h0000_0000, 1, 1, 0, 0, 0, 0);

        // Randomized fetches
        for (int i = 0; i < 30; i++) begin
            addr = $urandom & 32'h0000_0FFC;
            if ($urandom_range(4, 0) == 0) addr[1:0] = 2'($urandom_range(3, 1));
            a = int'($urandom_range(3, 0));
            r = int'($urandom_range(3, 0));
            hold = int'($urandom_range(3, 0));
            endMode = int'($urandom_range(2, 0));
            fAt = 0;
            fLen = 0;
            if (addr[1:0] == 2'b00 && $urandom_range(3, 0) == 0) begin
                fAt = int'($urandom_range(a + r + 2, 1));
                fLen = int'($urandom_range(3, 1));
            end
            runFetch(addr, a, r, hold, fAt, fLen, endMode);
        end
        checkOutput("araddr_stable_final", 64'(stabilityErrs), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/ifetch_axi_lite_master.md
Name: ifetch_axi_lite_master

Overview:
AXI4-Lite read-channel initiator that fetches instruction words on behalf of the core. It accepts one fetch request at a time on a valid/ready request port and issues the AR/R handshake toward the instruction-memory slave. It returns the fetched word, tagged with its address, on a valid/ready response port. It supports pipeline flush (branch/trap redirect) and misalignment detection, and sits between the CPU fetch stage and the AXI-Lite imem/interconnect.

Parameters:
ADDR_WIDTH, 32, width of request address and o_axi_araddr
DATA_WIDTH, 32, width of instruction word / i_axi_rdata
CHECK_ALIGN, 1, 1 = reject addresses with addr[1:0]!=0 without issuing AXI traffic; 0 = pass all addresses through

Ports:
clk  input  1  system clock, all logic on rising edge
resetn  input  1  asynchronous active-low reset
i_req_valid  input  1  core presents fetch request
o_req_ready  output  1  block can accept request
i_req_addr  input  ADDR_WIDTH  byte address of instruction
i_flush  input  1  discard all in-flight/pending fetches
o_rsp_valid  output  1  fetched word available
i_rsp_ready  input  1  core consumes response
o_rsp_data  output  DATA_WIDTH  fetched instruction word
o_rsp_addr  output  ADDR_WIDTH  address the word belongs to
o_rsp_err  output  1  1 = misaligned request, data forced 0
o_axi_araddr  output  ADDR_WIDTH  AXI read address
o_axi_arvalid  output  1  AXI read address valid
i_axi_arready  input  1  AXI read address ready
i_axi_rdata  input  DATA_WIDTH  AXI read data
i_axi_rvalid  input  1  AXI read data valid
o_axi_rready  output  1  AXI read data ready

Behaviour:
- Reset (async, resetn=0): state IDLE; all outputs 0 (o_req_ready=0 only while resetn=0, then 1 in IDLE); drop flag 0; address/data registers 0.
- States: IDLE, ADDR, DATA, RESP (encoding in package).
- IDLE: o_req_ready=1. On i_req_valid: latch addr, go to ADDR, o_axi_arvalid=1 next cycle, o_axi_araddr=latched addr. If CHECK_ALIGN and addr[1:0]!=0: go to RESP with o_rsp_err=1, o_rsp_data=0, no AXI activity.
- ADDR: o_axi_arvalid held 1 and o_axi_araddr held stable until i_axi_arready=1 (never withdrawn, AXI rule). On handshake, arvalid=0 next cycle and state goes to DATA.
- DATA: o_axi_rready=1. On i_axi_rvalid: capture rdata. If drop=0, go to RESP. If drop=1, clear drop and go to IDLE (word discarded).
- RESP: o_rsp_valid=1 with data/addr/err stable until i_rsp_ready=1, then go to IDLE. o_req_ready=0 outside IDLE.
- Latency: request accepted at cycle N gives arvalid at N+1. o_rsp_valid asserts the cycle after the R handshake. Against a slave with 1-cycle arready and 1-cycle rvalid, the response is valid at N+4 or N+5.
- Flush applies only to transactions accepted in earlier cycles; a request accepted in the same cycle as i_flush in IDLE is kept.
  - In ADDR or DATA: set drop=1; the AXI transaction completes normally but its data is never presented.
  - In RESP: o_rsp_valid clears next cycle, go to IDLE.
  - In IDLE: no effect.
- Flush and i_rsp_ready in the same RESP cycle: the response counts as consumed (handshake already occurred); go to IDLE.
- Repeated flushes while drop=1 have no additional effect (single outstanding).
- Exactly one outstanding AXI read at any time; the block never issues AR while in DATA or RESP.
- Data width: rdata passes through unmodified; no byte-lane manipulation.

Decomposition:
- Shared package (e.g. axi_lite_pkg): state localparams (IDLE/ADDR/DATA/RESP), word-alignment mask constant, default ADDR/DATA widths shared with the imem slave.
- Single flat module, no sub-module. The response holding register is a few lines and stays inline.

Test Plan:
1. Single fetch, addr 0x0000_0010, slave returns 0x0051_3093 -> araddr=0x10, o_rsp_data=0x00513093, o_rsp_addr=0x10, err=0.
2. Slave delays arready 3 cycles, rvalid 2 cycles -> arvalid/araddr stable throughout, exactly one AR handshake, correct data returned.
3. Request addr 0x0000_0006 with CHECK_ALIGN=1 -> no arvalid ever, o_rsp_valid next cycle with err=1, data=0.
4. Flush asserted one cycle after arvalid rises -> AR and R handshakes still complete, o_rsp_valid stays 0, o_req_ready=1 afterwards; next fetch 0x20 returns its own data.
5. o_rsp_valid held with i_rsp_ready=0 for 5 cycles -> data/addr stable, o_req_ready=0. Then flush -> rsp_valid drops next cycle.
6. resetn pulsed low in DATA state -> all outputs 0 immediately, IDLE after release. A fresh fetch of 0x0 returns the correct word.
